// File: rtl/npc_seq_ctrl.sv
// rtl/npc_seq_ctrl.sv - multi-cycle fetch/decode/exec/writeback sequencer for the NPC core
//
// Purpose: steps one instruction at a time through FETCH, DECODE, EXEC and WB.
//   It owns the architectural PC and the latched instruction register. It stops
//   for good on ebreak (HALT) or on a fault (TRAP), and it keeps cycle and
//   retire counters.
// Ports:
//   clk, rst                     core clock, asynchronous active-high reset
//   ifu_req_o / ifu_pc_o         fetch request and fetch address
//   ifu_vld_i / ifu_instr_i      fetched instruction handshake
//   instr_idu_o / pc_idu_o       latched instruction and its PC, to the decoder
//   idu_invld_i / idu_ebreak_i   decoder classification of the latched instruction
//   exu_start_o                  start pulse, driven in the first EXEC cycle only
//   exu_done_i                   execute result ready
//   exu_wb_en_i                  execute result writes rd
//   exu_next_pc_i                next PC computed by the execute unit
//   wrtbck_en_o                  register-file write enable, driven in WB only
//   halt_o / trap_o              sticky terminal status
//   trap_cause_o                 trap cause: 1 invalid, 2 exu timeout, 3 misaligned next PC
//   cycle_cnt_o / instret_cnt_o  running-cycle and retired-instruction counters
//   state_o                      current FSM state, for debug
module npc_seq_ctrl #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    INST_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = 32'h8000_0000,
  parameter int                    CNT_WIDTH   = 64,
  parameter int                    EXU_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ifu_req_o,
  output logic [ADDR_WIDTH-1:0] ifu_pc_o,
  input  logic                  ifu_vld_i,
  input  logic [INST_WIDTH-1:0] ifu_instr_i,
  output logic [INST_WIDTH-1:0] instr_idu_o,
  output logic [ADDR_WIDTH-1:0] pc_idu_o,
  input  logic                  idu_invld_i,
  input  logic                  idu_ebreak_i,
  output logic                  exu_start_o,
  input  logic                  exu_done_i,
  input  logic                  exu_wb_en_i,
  input  logic [ADDR_WIDTH-1:0] exu_next_pc_i,
  output logic                  wrtbck_en_o,
  output logic                  halt_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o,
  output logic [CNT_WIDTH-1:0]  cycle_cnt_o,
  output logic [CNT_WIDTH-1:0]  instret_cnt_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [7:0] WDOG_MAX = 8'(EXU_TIMEOUT);

  state_t                  state, state_nxt;
  logic [1:0]              cause_q, cause_nxt;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_idu_q, next_pc_q;
  logic [INST_WIDTH-1:0]   ir_q;
  logic [7:0]              wdog_q;
  logic                    wb_en_q;
  logic                    first_exec_q;
  logic [CNT_WIDTH-1:0]    cycle_q, instret_q;
  logic                    misaligned;

  assign misaligned = (exu_next_pc_i[1:0] != 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: if (ifu_vld_i) state_nxt = S_DECODE;
      S_DECODE: begin
        // An invalid flag takes priority over ebreak.
        if (idu_invld_i) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd1;
        end else if (idu_ebreak_i) begin
          state_nxt = S_HALT;
        end else begin
          state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        // If done arrives in the final watchdog cycle, it wins over the timeout.
        if (exu_done_i) begin
          if (misaligned) begin
            state_nxt = S_TRAP;
            cause_nxt = 2'd3;
          end else begin
            state_nxt = S_WB;
          end
        end else if (wdog_q == WDOG_MAX) begin
          state_nxt = S_TRAP;
          cause_nxt = 2'd2;
        end
      end
      S_WB:    state_nxt = S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pc_idu_q     <= '0;
      next_pc_q    <= '0;
      ir_q         <= '0;
      wdog_q       <= '0;
      wb_en_q      <= 1'b0;
      first_exec_q <= 1'b0;
      cause_q      <= 2'd0;
      cycle_q      <= '0;
      instret_q    <= '0;
    end else begin
      cause_q <= cause_nxt;
      if (state != S_HALT && state != S_TRAP) cycle_q <= cycle_q + 1'b1;
      case (state)
        S_FETCH: begin
          if (ifu_vld_i) begin
            ir_q     <= ifu_instr_i;
            pc_idu_q <= pc_q;
          end
        end
        S_DECODE: begin
          wdog_q       <= '0;
          first_exec_q <= 1'b1;
        end
        S_EXEC: begin
          first_exec_q <= 1'b0;
          if (exu_done_i) begin
            wb_en_q   <= exu_wb_en_i;
            next_pc_q <= exu_next_pc_i;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        S_WB: begin
          pc_q      <= next_pc_q;
          instret_q <= instret_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ifu_req_o     = (state == S_FETCH);
  assign ifu_pc_o      = pc_q;
  assign instr_idu_o   = ir_q;
  assign pc_idu_o      = pc_idu_q;
  assign exu_start_o   = (state == S_EXEC) && first_exec_q;
  assign wrtbck_en_o   = (state == S_WB) && wb_en_q;
  assign halt_o        = (state == S_HALT);
  assign trap_o        = (state == S_TRAP);
  assign trap_cause_o  = cause_q;
  assign cycle_cnt_o   = cycle_q;
  assign instret_cnt_o = instret_q;
  assign state_o       = state;

endmodule

// File: tb/tb_npc_seq_ctrl.sv
// tb/tb_npc_seq_ctrl.sv - directed self-checking bench for npc_seq_ctrl
module tb_npc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_o;
  logic [31:0] ifu_pc_o;
  logic        ifu_vld_i = 1'b0;
  logic [31:0] ifu_instr_i = '0;
  logic [31:0] instr_idu_o;
  logic [31:0] pc_idu_o;
  logic        idu_invld_i = 1'b0;
  logic        idu_ebreak_i = 1'b0;
  logic        exu_start_o;
  logic        exu_done_i = 1'b0;
  logic        exu_wb_en_i = 1'b0;
  logic [31:0] exu_next_pc_i = '0;
  logic        wrtbck_en_o;
  logic        halt_o;
  logic        trap_o;
  logic [1:0]  trap_cause_o;
  logic [63:0] cycle_cnt_o;
  logic [63:0] instret_cnt_o;
  logic [2:0]  state_o;

  int total = 0;
  int bad   = 0;

  npc_seq_ctrl dut (
    .clk(clk), .rst(rst),
    .ifu_req_o(ifu_req_o), .ifu_pc_o(ifu_pc_o),
    .ifu_vld_i(ifu_vld_i), .ifu_instr_i(ifu_instr_i),
    .instr_idu_o(instr_idu_o), .pc_idu_o(pc_idu_o),
    .idu_invld_i(idu_invld_i), .idu_ebreak_i(idu_ebreak_i),
    .exu_start_o(exu_start_o), .exu_done_i(exu_done_i),
    .exu_wb_en_i(exu_wb_en_i), .exu_next_pc_i(exu_next_pc_i),
    .wrtbck_en_o(wrtbck_en_o), .halt_o(halt_o), .trap_o(trap_o),
    .trap_cause_o(trap_cause_o), .cycle_cnt_o(cycle_cnt_o),
    .instret_cnt_o(instret_cnt_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    ifu_vld_i = 0; idu_invld_i = 0; idu_ebreak_i = 0; exu_done_i = 0;
    rst = 1;
    tick();
    rst = 0;
  endtask

  // From reset: IDLE -> FETCH -> DECODE -> first EXEC cycle.
  task automatic reset_to_exec();
    do_reset();
    tick();
    ifu_vld_i = 1; ifu_instr_i = 32'h0000_0013;
    tick();
    ifu_vld_i = 0;
    tick();
  endtask

  logic [63:0] cyc_snap;

  initial begin
    // reset state
    tick();
    chk("rst_state", state_o, 0);
    chk("rst_pc", ifu_pc_o, 64'h8000_0000);
    chk("rst_ir", instr_idu_o, 0);
    chk("rst_req", ifu_req_o, 0);
    chk("rst_cycle", cycle_cnt_o, 0);
    rst = 0;

    // 1: zero-wait addi
    ifu_vld_i = 1; ifu_instr_i = 32'h0010_0093;
    exu_done_i = 1; exu_next_pc_i = 32'h8000_0004; exu_wb_en_i = 1;
    tick();
    chk("t1_fetch_state", state_o, 1);
    chk("t1_fetch_req", ifu_req_o, 1);
    tick();
    chk("t1_dec_state", state_o, 2);
    chk("t1_ir", instr_idu_o, 64'h0010_0093);
    chk("t1_pc_idu", pc_idu_o, 64'h8000_0000);
    tick();
    chk("t1_start", exu_start_o, 1);
    tick();
    chk("t1_wb_state", state_o, 4);
    chk("t1_wb_en", wrtbck_en_o, 1);
    ifu_vld_i = 0; exu_done_i = 0;
    tick();
    chk("t1_pc", ifu_pc_o, 64'h8000_0004);
    chk("t1_instret", instret_cnt_o, 1);
    chk("t1_cycle", cycle_cnt_o, 5);
    chk("t1_wb_drop", wrtbck_en_o, 0);

    // 2: fetch waits 3 cycles, exec takes 2 cycles
    tick(); tick(); tick();
    chk("t2_wait_state", state_o, 1);
    ifu_vld_i = 1; ifu_instr_i = 32'h0020_0113;
    tick();
    ifu_vld_i = 0;
    chk("t2_dec_state", state_o, 2);
    tick();
    chk("t2_start1", exu_start_o, 1);
    tick();
    chk("t2_exec2_state", state_o, 3);
    chk("t2_start2", exu_start_o, 0);
    exu_done_i = 1; exu_next_pc_i = 32'h8000_0008; exu_wb_en_i = 0;
    tick();
    exu_done_i = 0;
    chk("t2_wb_state", state_o, 4);
    chk("t2_wb_en", wrtbck_en_o, 0);
    chk("t2_start_wb", exu_start_o, 0);
    tick();
    chk("t2_instret", instret_cnt_o, 2);
    chk("t2_pc", ifu_pc_o, 64'h8000_0008);
    chk("t2_cycle", cycle_cnt_o, 13);

    // 4: third instr then ebreak
    ifu_vld_i = 1; ifu_instr_i = 32'h0030_0193;
    tick();
    ifu_vld_i = 0; exu_done_i = 1; exu_next_pc_i = 32'h8000_000c; exu_wb_en_i = 1;
    tick();
    tick();
    exu_done_i = 0;
    tick();
    chk("t4_instret3", instret_cnt_o, 3);
    ifu_vld_i = 1; ifu_instr_i = 32'h0010_0073;
    tick();
    ifu_vld_i = 0; idu_ebreak_i = 1;
    tick();
    idu_ebreak_i = 0;
    chk("t4_halt", halt_o, 1);
    chk("t4_state", state_o, 5);
    chk("t4_trap", trap_o, 0);
    chk("t4_instret", instret_cnt_o, 3);
    chk("t4_cycle", cycle_cnt_o, 19);
    ifu_vld_i = 1;
    for (int i = 0; i < 5; i++) tick();
    ifu_vld_i = 0;
    chk("t4_cycle_frozen", cycle_cnt_o, 19);
    chk("t4_req", ifu_req_o, 0);
    chk("t4_halt_sticky", halt_o, 1);
    chk("t4_pc", ifu_pc_o, 64'h8000_000c);

    // 3: invalid + ebreak -> trap cause 1
    do_reset();
    chk("t3_rst_instret", instret_cnt_o, 0);
    tick();
    ifu_vld_i = 1;
    tick();
    ifu_vld_i = 0; idu_invld_i = 1; idu_ebreak_i = 1;
    tick();
    idu_invld_i = 0; idu_ebreak_i = 0;
    chk("t3_trap", trap_o, 1);
    chk("t3_cause", trap_cause_o, 1);
    chk("t3_halt", halt_o, 0);
    chk("t3_instret", instret_cnt_o, 0);
    chk("t3_cycle", cycle_cnt_o, 3);
    tick(); tick();
    chk("t3_cycle_frozen", cycle_cnt_o, 3);
    chk("t3_start", exu_start_o, 0);

    // 5a: watchdog timeout
    reset_to_exec();
    chk("t5_exec", state_o, 3);
    for (int i = 0; i < 255; i++) tick();
    chk("t5_still_exec", state_o, 3);
    tick();
    chk("t5_trap", trap_o, 1);
    chk("t5_cause", trap_cause_o, 2);
    chk("t5_pc", ifu_pc_o, 64'h8000_0000);

    // 5b: done on the last watchdog cycle wins
    reset_to_exec();
    for (int i = 0; i < 255; i++) tick();
    exu_done_i = 1; exu_next_pc_i = 32'h8000_0010; exu_wb_en_i = 1;
    tick();
    exu_done_i = 0;
    chk("t5b_wb_state", state_o, 4);
    chk("t5b_wb_en", wrtbck_en_o, 1);
    chk("t5b_no_trap", trap_o, 0);
    tick();
    chk("t5b_pc", ifu_pc_o, 64'h8000_0010);

    // 6a: misaligned next PC
    reset_to_exec();
    exu_done_i = 1; exu_next_pc_i = 32'h8000_0006; exu_wb_en_i = 1;
    tick();
    exu_done_i = 0;
    chk("t6_trap", trap_o, 1);
    chk("t6_cause", trap_cause_o, 3);
    chk("t6_pc", ifu_pc_o, 64'h8000_0000);
    chk("t6_instret", instret_cnt_o, 0);
    chk("t6_wb_en", wrtbck_en_o, 0);

    // 6b: async reset mid-EXEC, after a retired instruction
    reset_to_exec();
    exu_done_i = 1; exu_next_pc_i = 32'h8000_0004; exu_wb_en_i = 1;
    tick(); tick();
    exu_done_i = 0;
    ifu_vld_i = 1;
    tick();
    ifu_vld_i = 0;
    tick();
    chk("t6b_exec", state_o, 3);
    chk("t6b_pc_before", ifu_pc_o, 64'h8000_0004);
    exu_done_i = 1; exu_next_pc_i = 32'h8000_0008;
    #2;
    rst = 1;
    #1;
    chk("t6b_state", state_o, 0);
    chk("t6b_pc", ifu_pc_o, 64'h8000_0000);
    chk("t6b_wb_en", wrtbck_en_o, 0);
    chk("t6b_cycle", cycle_cnt_o, 0);
    chk("t6b_instret", instret_cnt_o, 0);
    tick();
    chk("t6b_wb_en_hold", wrtbck_en_o, 0);
    exu_done_i = 0;
    rst = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
